// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch/PC sequencer: FSM state codes and halt error codes.
package pc_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Word alignment is the only legality check applied to a next-PC target.
  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_seq_perf.sv
// Performance counters for pc_sequencer: active cycles and retired instructions.
// Only instantiated when PC_SEQ_PERF_CNT_EN is defined.
module pc_seq_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        retire,
  output logic [31:0] retire_cnt,
  output logic [31:0] cycle_cnt
);

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      cycle_cnt  <= '0;
    end else begin
      if (retire) retire_cnt <= retire_cnt + 32'd1;
      if (active) cycle_cnt  <= cycle_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/PC controller: IDLE -> FETCH -> DECODE -> EXEC, halting on a
// misaligned target or fetch timeout. Optional counters under PC_SEQ_PERF_CNT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [31:0] pcnext,
  output logic [31:0] pc,
  output logic        pc_we,
  output logic        halted,
  output logic [1:0]  err,
  output logic [31:0] retire_cnt,
  output logic [31:0] cycle_cnt
);

  localparam int              WCW       = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(FETCH_TIMEOUT - 1);

  // Handshake: imem_req is held high for the whole FETCH state; the cycle in which
  // imem_ack is high (including the first one) transfers imem_rdata. exec_done is
  // a single-cycle completion strobe that only counts while in EXEC.
  logic [2:0]     state, state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           commit, align_fault, fetch_to;

  assign commit      = (state == ST_EXEC) && exec_done && is_aligned(pcnext);
  assign align_fault = (state == ST_EXEC) && exec_done && !is_aligned(pcnext);
  // Last allowed FETCH cycle with no ack; an ack on that same cycle still wins.
  assign fetch_to    = (state == ST_FETCH) && !imem_ack && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)      state_nxt = ST_DECODE;
        else if (fetch_to) state_nxt = ST_HALT;
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (commit)           state_nxt = run ? ST_FETCH : ST_IDLE;
        else if (align_fault) state_nxt = ST_HALT;
      end
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      ST_FETCH:  imem_req    = 1'b1;
      ST_DECODE: instr_valid = 1'b1;
      ST_HALT:   halted      = 1'b1;
      default:   ;
    endcase
    pc_we = commit;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      instr    <= '0;
      wait_cnt <= '0;
      err      <= ERR_NONE;
    end else begin
      if (commit) pc <= pcnext;
      if ((state == ST_FETCH) && imem_ack) instr <= imem_rdata;
      if ((state == ST_FETCH) && !imem_ack && !fetch_to) wait_cnt <= wait_cnt + WCW'(1);
      else                                             wait_cnt <= '0;
      if (fetch_to)         err <= ERR_TIMEOUT;
      else if (align_fault) err <= ERR_ALIGN;
    end
  end

`ifdef PC_SEQ_PERF_CNT_EN
  logic active;
  assign active = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);

  pc_seq_perf u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (active),
    .retire     (commit),
    .retire_cnt (retire_cnt),
    .cycle_cnt  (cycle_cnt)
  );
`else
  assign retire_cnt = '0;
  assign cycle_cnt  = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized instruction episodes
// checked against a transaction-level model of pc, instr, err and counters.
module tb_pc_sequencer;

  localparam int          TO     = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk, rst_n, run;
  logic        imem_req, imem_ack, instr_valid, exec_done, pc_we, halted;
  logic [31:0] imem_addr, imem_rdata, instr, pcnext, pc, retire_cnt, cycle_cnt;
  logic [1:0]  err;

  pc_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .pcnext(pcnext), .pc(pc), .pc_we(pc_we),
    .halted(halted), .err(err), .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc, m_instr, m_retire, m_cycles;
  logic        m_halted;
  logic [1:0]  m_err;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_common();
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("err", {30'd0, err}, {30'd0, m_err});
`ifdef PC_SEQ_PERF_CNT_EN
    check("retire_cnt", retire_cnt, m_retire);
    check("cycle_cnt", cycle_cnt, m_cycles);
`else
    check("retire_cnt", retire_cnt, 32'd0);
    check("cycle_cnt", cycle_cnt, 32'd0);
`endif
  endtask

  // driver tasks: each starts and ends at posedge+1
  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    #2;
    m_pc = RST_PC; m_instr = '0; m_retire = '0; m_cycles = '0;
    m_halted = 1'b0; m_err = 2'b00;
    exp_q.delete();
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc_we", {31'd0, pc_we}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc_abs", pc, 32'h0000_3000);
    check_common();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic go);
    for (int i = 0; i <= n; i++) begin
      run        = (i == n) ? go : 1'b0;
      imem_ack   = 1'($urandom_range(0, 1));
      exec_done  = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      pcnext     = $urandom;
      @(negedge clk);
      check("idle_req", {31'd0, imem_req}, 32'd0);
      check("idle_valid", {31'd0, instr_valid}, 32'd0);
      check("idle_pc_we", {31'd0, pc_we}, 32'd0);
      check("idle_instr", instr, m_instr);
      check_common();
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; exec_done = 1'b0;
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      run       = 1'($urandom_range(0, 1));
      imem_ack  = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      pcnext    = $urandom;
      @(negedge clk);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_pc_we", {31'd0, pc_we}, 32'd0);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
      check_common();
      @(posedge clk); #1;
    end
  endtask

  // Some FETCH cycles without ack, then an asynchronous reset aborts the instruction.
  task automatic abort_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      check("abort_req", {31'd0, imem_req}, 32'd1);
      check_common();
      m_cycles++;
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  // One instruction from the first FETCH cycle: ack after ack_dly cycles, exec_done
  // after exec_dly EXEC cycles with pcnext = pc + off, run = run_c at commit.
  task automatic do_instr(input int ack_dly, input int exec_dly, input logic [31:0] off,
                          input logic run_c, input logic noisy);
    logic [31:0] word, target;
    logic        got;
    got = 1'b0;
    for (int k = 0; k < TO; k++) begin
      imem_ack   = (k == ack_dly);
      word       = $urandom;
      imem_rdata = word;
      exec_done  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      pcnext     = $urandom;
      run        = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      check("fetch_req", {31'd0, imem_req}, 32'd1);
      check("fetch_instr_hold", instr, m_instr);
      check("fetch_pc_we", {31'd0, pc_we}, 32'd0);
      check("fetch_valid", {31'd0, instr_valid}, 32'd0);
      check_common();
      m_cycles++;
      @(posedge clk); #1;
      if (k == ack_dly) begin
        exp_q.push_back(word);
        got = 1'b1;
        break;
      end
    end
    imem_ack = 1'b0;
    if (!got) begin
      m_halted = 1'b1;
      m_err    = 2'b10;
      return;
    end
    imem_ack   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    imem_rdata = $urandom;
    exec_done  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    run        = noisy ? 1'($urandom_range(0, 1)) : run_c;
    @(negedge clk);
    m_instr = exp_q.pop_front();
    check("decode_valid", {31'd0, instr_valid}, 32'd1);
    check("decode_req", {31'd0, imem_req}, 32'd0);
    check("decode_instr", instr, m_instr);
    check("decode_pc_we", {31'd0, pc_we}, 32'd0);
    check_common();
    m_cycles++;
    @(posedge clk); #1;
    target = m_pc + off;
    for (int e = 0; e <= exec_dly; e++) begin
      exec_done  = (e == exec_dly);
      pcnext     = (e == exec_dly) ? target : $urandom;
      run        = (e == exec_dly || !noisy) ? run_c : 1'($urandom_range(0, 1));
      imem_ack   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("exec_pc_we", {31'd0, pc_we},
            {31'd0, (e == exec_dly) && (target[1:0] == 2'b00)});
      check("exec_req", {31'd0, imem_req}, 32'd0);
      check("exec_valid", {31'd0, instr_valid}, 32'd0);
      check("exec_instr", instr, m_instr);
      check_common();
      m_cycles++;
      @(posedge clk); #1;
    end
    exec_done = 1'b0; imem_ack = 1'b0;
    if (target[1:0] == 2'b00) begin
      m_pc = target;
      m_retire++;
    end else begin
      m_halted = 1'b1;
      m_err    = 2'b01;
    end
  endtask

  // stimulus
  logic        in_idle;
  int          ack_dly;
  logic [31:0] off;
  logic        run_c;
  int          sel;

  initial begin
    rst_n = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; pcnext = '0;
    @(posedge clk); #1;
    do_reset();

    // sequential flow, back-to-back
    idle(1, 1'b1);
    do_instr(0, 0, 32'd4, 1'b1, 1'b0);
    do_instr(0, 0, 32'd4, 1'b1, 1'b0);
    do_instr(0, 0, 32'd4, 1'b0, 1'b0);
    @(negedge clk);
    check("seq_pc", pc, 32'h0000_300C);
`ifdef PC_SEQ_PERF_CNT_EN
    check("seq_retire", retire_cnt, 32'd3);
    check("seq_cycles", cycle_cnt, 32'd9);
`else
    check("seq_retire", retire_cnt, 32'd0);
    check("seq_cycles", cycle_cnt, 32'd0);
`endif
    @(posedge clk); #1;

    // run dropped in DECODE, then restart at the committed pc
    idle(0, 1'b1);
    do_instr(1, 1, 32'd16, 1'b0, 1'b0);
    idle(2, 1'b1);
    do_instr(0, 0, 32'd4, 1'b0, 1'b0);
    check("restart_pc", pc, 32'h0000_3020);

    // misaligned target
    do_reset();
    idle(0, 1'b1);
    do_instr(0, 0, 32'd6, 1'b1, 1'b0);
    hold_halt(3);
    check("misalign_pc", pc, 32'h0000_3000);
    check("misalign_err", {30'd0, err}, 32'd1);

    // timeout, then ack on the last allowed cycle
    do_reset();
    idle(0, 1'b1);
    do_instr(TO, 0, 32'd4, 1'b1, 1'b0);
    hold_halt(2);
    check("timeout_err", {30'd0, err}, 32'd2);
    do_reset();
    idle(0, 1'b1);
    do_instr(TO - 1, 0, 32'd4, 1'b1, 1'b0);
    do_instr(TO - 1, 2, 32'd4, 1'b0, 1'b0);
    in_idle = 1'b1;

    // randomized episodes
    for (int ep = 0; ep < 120; ep++) begin
      if (m_halted) begin
        hold_halt($urandom_range(1, 3));
        do_reset();
        in_idle = 1'b1;
      end
      if (in_idle) idle($urandom_range(0, 2), 1'b1);
      if ($urandom_range(0, 15) == 0) begin
        abort_fetch($urandom_range(0, TO - 1));
        in_idle = 1'b1;
        continue;
      end
      ack_dly = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1);
      sel = $urandom_range(0, 9);
      off = $urandom;
      if (sel == 0)     off[1:0] = 2'($urandom_range(1, 3));
      else if (sel < 5) off = 32'd4;
      else              off[1:0] = 2'b00;
      run_c = ($urandom_range(0, 3) != 0);
      do_instr(ack_dly, $urandom_range(0, 3), off, run_c, 1'b1);
      in_idle = !run_c;
    end
    if (m_halted) hold_halt(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
